if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  Parametrised IF->ID pipeline boundary. Replaces the fixed always-enabled register pair.
//  Carries {pc, inst} with valid/ready handshakes on both sides.
//  Includes a 2-entry skid buffer, so full throughput holds while ID stalls.
//  A synchronous flush kills all held beats and presents NOP to ID.
// PARAMETERS
//  PC_WIDTH    64            width of pc path (matches ImmWidth)
//  INST_WIDTH  32            width of instruction path (matches InstWidth)
//  NOP_INST    32'h00000013  value presented on out_inst when no valid beat is held
//  PC_RESET    0             value of out_pc after reset
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-low reset
//  in_valid   in   1           IF presents a beat
//  in_ready   out  1           stage can accept a beat this cycle
//  in_pc      in   PC_WIDTH    pc of fetched instruction
//  in_inst    in   INST_WIDTH  fetched instruction
//  flush      in   1           kill all held and incoming beats (branch/jump/trap redirect)
//  out_valid  out  1           beat available to ID
//  out_ready  in   1           ID consumes the beat this cycle
//  out_pc     out  PC_WIDTH    pc of presented beat
//  out_inst   out  INST_WIDTH  presented instruction; NOP_INST when out_valid=0
// BEHAVIOUR
//  - Handshakes: accept when in_valid&in_ready; drain when out_valid&out_ready.
//  - Once out_valid=1, out_pc/out_inst stay stable until drained or flushed.
//  - Storage: main entry (drives outputs) + skid entry. All outputs come straight from registers.
//  - FSM state (2 bits):
//     EMPTY: no entry valid.
//     BUSY:  main entry valid.
//     FULL:  main and skid entries valid.
//  - in_ready = (state != FULL), registered; out_valid = (state != EMPTY).
//  - Transitions (flush=0):
//     EMPTY: accept -> BUSY, main<=in. No combinational in->out path: latency 1 cycle.
//     BUSY:  accept & drain  -> BUSY, main<=in.
//            accept & !drain -> FULL, skid<=in.
//            drain & !accept -> EMPTY.
//            neither         -> hold.
//     FULL:  drain -> BUSY, main<=skid. No accept is possible in FULL.
//  - Flush has priority over all other events, including a same-cycle accept or drain.
//     Next cycle: state=EMPTY, out_valid=0, out_inst=NOP_INST.
//     out_pc holds its previous value. The skid entry is invalidated.
//     A beat offered on the flush cycle is dropped. IF must redirect on that same flush.
//  - In EMPTY, out_inst reads NOP_INST. A NOP is also loaded into the main inst register on a drain-to-EMPTY.
//  - Reset (rst=0, async): state=EMPTY, out_valid=0, out_pc=PC_RESET, out_inst=NOP_INST, in_ready=1.
//     Reset mid-transfer discards both entries. The first accept is possible in the first clock after release.
//  - No beat may be duplicated, reordered or lost, except by flush.
//  - Widths are carried unmodified; no arithmetic on pc.
// TESTING
//  1. Reset, then stream pc=0x8000_0000+4k, k=0..7, out_ready=1.
//     -> out_valid=1 from cycle 1 onward. Beats appear in order, one per cycle. in_ready stays 1.
//  2. Accept pc=0x80000000, then pc=0x80000004 with out_ready=0.
//     -> state FULL, in_ready=0, out_pc=0x80000000 stable.
//     Raise out_ready -> next cycle out_pc=0x80000004, in_ready=1.
//  3. FULL state, assert flush with out_ready=1 and in_valid=1.
//     -> next cycle out_valid=0, out_inst=0x00000013, in_ready=1. No beat reaches ID.
//  4. BUSY with pc=0x100, simultaneous accept pc=0x104 and drain.
//     -> next cycle out_pc=0x104, state BUSY, no bubble.
//  5. Drop rst while FULL, between clock edges.
//     -> outputs go to reset values immediately. After release, accept pc=0x200 -> out_pc=0x200 one cycle later.
//  6. Random in_valid/out_ready/flush (10k cycles) vs. scoreboard queue.
//     -> in-order delivery and no drops except flushed beats. Held outputs stay stable under backpressure.

Source files
------------

// File: rtl/if_id_stage.sv
// IF->ID pipeline boundary: valid/ready on both sides, main + skid entry so IF keeps
// streaming while ID stalls, and a synchronous flush that empties the stage.
module if_id_stage #(
    parameter int                    PC_WIDTH   = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h00000013),
    parameter logic [PC_WIDTH-1:0]   PC_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   skid_pc;
    logic [INST_WIDTH-1:0] skid_inst;

    logic accept, drain;
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Outputs are the main entry itself; in_ready/out_valid are kept as registered
    // copies of the state decode so no output has logic after a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pc    <= PC_RESET;
            out_inst  <= NOP_INST;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (flush) begin
            // out_pc is left alone; only the inst lane shows the bubble.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        out_pc    <= in_pc;
                        out_inst  <= in_inst;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        out_pc   <= in_pc;
                        out_inst <= in_inst;
                    end else if (accept) begin
                        state     <= FULL;
                        in_ready  <= 1'b0;
                        skid_pc   <= in_pc;
                        skid_inst <= in_inst;
                    end else if (drain) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_inst  <= NOP_INST;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state    <= BUSY;
                        in_ready <= 1'b1;
                        out_pc   <= skid_pc;
                        out_inst <= skid_inst;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_inst  <= NOP_INST;
                end
            endcase
        end
    end

endmodule
